rawp_stream_writer: RTL and testbench
=====================================

Name: rawp_stream_writer

Overview:
Upstream feeder for the dual-port DMA RAM's raw port B. It accepts a 32-bit valid/ready word stream from the capture logic and writes each word into a CPU-configured ring region of the RAM. The CPU drains the ring over Wishbone port A and returns space by advancing a read pointer. The block reports fill level, a sticky address-error flag and an optional watermark interrupt.

Parameters:
WB_ADDR_WIDTH, 12, byte-address width of the RAM raw port; must equal the RAM's WB_ADDR_WIDTH.
LEN_WIDTH, WB_ADDR_WIDTH-2, width of all word indices, lengths and pointers.

Ports:
clk_i  in  1  single clock; RAM rawp_clk is driven from the same net.
rst_i  in  1  synchronous reset, active-high.
s_valid_i  in  1  stream word valid.
s_data_i  in  32  stream word.
s_ready_o  out  1  stream accept.
cfg_en_i  in  1  run enable.
cfg_base_i  in  LEN_WIDTH  ring base, as a word index.
cfg_len_i  in  LEN_WIDTH  ring length in words; must be >= 2.
cfg_wmark_i  in  LEN_WIDTH  interrupt watermark, in words.
rd_ptr_i  in  LEN_WIDTH  new CPU read pointer, relative to base.
rd_ptr_we_i  in  1  load strobe for rd_ptr_i.
rawp_adr_o  out  WB_ADDR_WIDTH  RAM byte address.
rawp_dat_o  out  32  RAM write data.
rawp_we_o  out  1  RAM write enable.
rawp_stall_i  in  1  RAM registered bad-address flag.
wr_ptr_o  out  LEN_WIDTH  write pointer, relative to base.
level_o  out  LEN_WIDTH  words in ring.
err_o  out  1  sticky address error.
irq_o  out  1  watermark interrupt, level-sensitive.

Behaviour:
- Reset: s_ready_o=0, rawp_adr_o=0, rawp_dat_o=0, rawp_we_o=0, wr_ptr_o=0, rd_ptr=0, level_o=0, err_o=0, irq_o=0, FSM=IDLE.
- cfg_base_i, cfg_len_i and cfg_wmark_i are sampled only in IDLE; they are held in internal registers while running.
- FSM states:
  - IDLE: s_ready_o=0; wr_ptr and rd_ptr held at 0; err_o cleared. cfg_en_i=1 -> latch cfg, go to RUN.
  - RUN: s_ready_o = ~full. Error detected -> ERR. cfg_en_i=0 -> DRAIN.
  - DRAIN: s_ready_o=0. One cycle, to let an already-registered write and its stall check complete. Error detected -> ERR, else -> IDLE.
  - ERR: s_ready_o=0; err_o=1. cfg_en_i=0 -> IDLE.
- Write path:
  - Handshake: s_valid_i & s_ready_o at edge N.
  - At edge N+1 the block registers rawp_adr_o = (base+wr_ptr)<<2 (low two bits always 0), rawp_dat_o = s_data_i, rawp_we_o=1.
  - wr_ptr increments and wraps from len-1 to 0.
  - rawp_we_o is a one-cycle pulse per word. Back-to-back words are allowed: 1 word/clock.
- Error detection: the RAM registers stall from the presented address, so the check is we_d & rawp_stall_i, where we_d is rawp_we_o delayed one cycle. It is sampled in RUN and DRAIN.
- Level and full:
  - level = (wr_ptr >= rd_ptr) ? wr_ptr-rd_ptr : wr_ptr+len-rd_ptr.
  - full = (level == len-1); one slot is kept empty.
  - level_o is registered and updated every cycle.
- Read-pointer updates:
  - rd_ptr_we_i loads rd_ptr from rd_ptr_i in RUN only.
  - A value >= len is ignored.
  - A simultaneous accept and rd_ptr load both take effect. full for that cycle uses the pre-update registers, which is conservative and never overwrites.
- base+len exceeding RAM depth is not checked here; it surfaces as an error via rawp_stall_i.
- Reset mid-write: any pending rawp_we_o is dropped at the reset edge.

Optional Feature:
RAWP_WRITER_IRQ_EN
- Defined: irq_o = registered (state==RUN & level_o >= wmark & wmark != 0) | err_o.
- Not defined: irq_o tied to 0; cfg_wmark_i unused. All other behaviour is identical.

Test Plan:
- Reset, then base=16, len=8, en=1, push 0xA0..0xA3 back-to-back -> four rawp_we_o pulses, addresses 0x40,0x44,0x48,0x4C, each one cycle after its accept; wr_ptr_o=4, level_o=4.
- len=8, no rd_ptr writes, s_valid_i held high -> exactly 7 words accepted; s_ready_o=0 with level_o=7. Load rd_ptr_i=3 -> s_ready_o=1 next cycle; 3 more accepted.
- Wrap: len=4, advance rd_ptr to keep space, push 6 words -> word 5 written at base index 0 (address base<<2); wr_ptr_o=2.
- base=len=so that base+len exceeds RAM depth, RAM stub raises rawp_stall_i -> err_o=1 two cycles after the offending accept; s_ready_o=0; en=0 -> IDLE with err_o=0.
- Accept and rd_ptr load in the same cycle at level 7/len 8 -> no accept that cycle; the following cycle accepts.
- With RAWP_WRITER_IRQ_EN, wmark=3: irq_o rises the cycle after level_o reaches 3 and falls after rd_ptr catches up. Without the macro, irq_o stays 0 throughout.

Source files
------------

// File: rtl/rawp_stream_writer.sv
// Ring writer feeding the DMA RAM raw port B from a 32-bit valid/ready stream; optional irq via RAWP_WRITER_IRQ_EN.
// Latency: rawp write is registered the clock after the stream handshake; stall-based error lands two clocks later.
// Backpressure: s_ready_o drops when the ring holds len-1 words or the block is not in RUN.
module rawp_stream_writer #(
    parameter int WB_ADDR_WIDTH = 12,
    parameter int LEN_WIDTH     = WB_ADDR_WIDTH - 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     s_valid_i,
    input  logic [31:0]              s_data_i,
    output logic                     s_ready_o,
    input  logic                     cfg_en_i,
    input  logic [LEN_WIDTH-1:0]     cfg_base_i,
    input  logic [LEN_WIDTH-1:0]     cfg_len_i,
    input  logic [LEN_WIDTH-1:0]     cfg_wmark_i,
    input  logic [LEN_WIDTH-1:0]     rd_ptr_i,
    input  logic                     rd_ptr_we_i,
    output logic [WB_ADDR_WIDTH-1:0] rawp_adr_o,
    output logic [31:0]              rawp_dat_o,
    output logic                     rawp_we_o,
    input  logic                     rawp_stall_i,
    output logic [LEN_WIDTH-1:0]     wr_ptr_o,
    output logic [LEN_WIDTH-1:0]     level_o,
    output logic                     err_o,
    output logic                     irq_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERR} state_t;

    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [LEN_WIDTH-1:0]     base_q, base_d, len_q, len_d;
    logic [LEN_WIDTH-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LEN_WIDTH-1:0]     level_q, level_d, slot;
    logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [31:0]              dat_q, dat_d;
    logic                     we_q, we_d, we_dly_q, err_q, err_d, irq_q, irq_d;
    logic                     full, ready, accept, err_det, rd_load;
`ifdef RAWP_WRITER_IRQ_EN
    logic [LEN_WIDTH-1:0]     wmark_q, wmark_d;
`else
    logic [LEN_WIDTH-1:0]     unused_wmark;
    assign unused_wmark = cfg_wmark_i;
`endif

    function automatic logic [LEN_WIDTH-1:0] calc_level(input logic [LEN_WIDTH-1:0] wr,
                                                        input logic [LEN_WIDTH-1:0] rd,
                                                        input logic [LEN_WIDTH-1:0] len);
        return (wr >= rd) ? (wr - rd) : (wr + len - rd);
    endfunction

    always_comb begin
        // level_q always equals the level of the current pointers, so it doubles as the full check
        full    = (level_q == len_q - ONE);
        ready   = (state_q == RUN) && !full;
        accept  = s_valid_i && ready;
        err_det = we_dly_q && rawp_stall_i && ((state_q == RUN) || (state_q == DRAIN));
        rd_load = (state_q == RUN) && rd_ptr_we_i && (rd_ptr_i < len_q);
        slot    = base_q + wr_ptr_q;

        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
`ifdef RAWP_WRITER_IRQ_EN
        wmark_d = wmark_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_en_i) begin
                    state_d = RUN;
                    base_d  = cfg_base_i;
                    len_d   = cfg_len_i;
`ifdef RAWP_WRITER_IRQ_EN
                    wmark_d = cfg_wmark_i;
`endif
                end
            end
            RUN:     if (err_det) state_d = ERR; else if (!cfg_en_i) state_d = DRAIN;
            DRAIN:   state_d = err_det ? ERR : IDLE;
            ERR:     if (!cfg_en_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) wr_ptr_d = (wr_ptr_q == len_q - ONE) ? '0 : wr_ptr_q + ONE;
        if (rd_load) rd_ptr_d = rd_ptr_i;
        if (state_d == IDLE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        level_d = calc_level(wr_ptr_d, rd_ptr_d, len_d);

        we_d  = accept;
        adr_d = adr_q;
        dat_d = dat_q;
        if (accept) begin
            adr_d = WB_ADDR_WIDTH'({slot, 2'b00});
            dat_d = s_data_i;
        end

        err_d = (state_d == ERR);
`ifdef RAWP_WRITER_IRQ_EN
        irq_d = ((state_q == RUN) && (level_q >= wmark_q) && (wmark_q != '0)) || err_q;
`else
        irq_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            we_dly_q <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
`ifdef RAWP_WRITER_IRQ_EN
            wmark_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            we_q     <= we_d;
            we_dly_q <= we_q;
            err_q    <= err_d;
            irq_q    <= irq_d;
`ifdef RAWP_WRITER_IRQ_EN
            wmark_q  <= wmark_d;
`endif
        end
    end

    assign s_ready_o  = ready;
    assign rawp_adr_o = adr_q;
    assign rawp_dat_o = dat_q;
    assign rawp_we_o  = we_q;
    assign wr_ptr_o   = wr_ptr_q;
    assign level_o    = level_q;
    assign err_o      = err_q;
    assign irq_o      = irq_q;
endmodule

// File: tb/tb_rawp_stream_writer.sv
// Directed bench for rawp_stream_writer with a RAM stub that flags writes beyond RAM_WORDS.
module tb_rawp_stream_writer;
    localparam int AW        = 12;
    localparam int LW        = 10;
    localparam int RAM_WORDS = 128;
`ifdef RAWP_WRITER_IRQ_EN
    localparam logic [31:0] IRQ_ON = 32'd1;
`else
    localparam logic [31:0] IRQ_ON = 32'd0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          s_valid_i, s_ready_o;
    logic [31:0]   s_data_i;
    logic          cfg_en_i;
    logic [LW-1:0] cfg_base_i, cfg_len_i, cfg_wmark_i, rd_ptr_i;
    logic          rd_ptr_we_i;
    logic [AW-1:0] rawp_adr_o;
    logic [31:0]   rawp_dat_o;
    logic          rawp_we_o, stall_q;
    logic [LW-1:0] wr_ptr_o, level_o;
    logic          err_o, irq_o;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_i = ~clk_i;

    rawp_stream_writer #(.WB_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
        .cfg_en_i(cfg_en_i), .cfg_base_i(cfg_base_i), .cfg_len_i(cfg_len_i),
        .cfg_wmark_i(cfg_wmark_i), .rd_ptr_i(rd_ptr_i), .rd_ptr_we_i(rd_ptr_we_i),
        .rawp_adr_o(rawp_adr_o), .rawp_dat_o(rawp_dat_o), .rawp_we_o(rawp_we_o),
        .rawp_stall_i(stall_q), .wr_ptr_o(wr_ptr_o), .level_o(level_o),
        .err_o(err_o), .irq_o(irq_o)
    );

    // RAM stub: registers a bad-address flag for writes past its depth
    always_ff @(posedge clk_i) begin
        if (rst_i) stall_q <= 1'b0;
        else       stall_q <= rawp_we_o && (rawp_adr_o >= AW'(RAM_WORDS * 4));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] adr);
        chk("push_rdy", 32'(s_ready_o), 32'd1);
        s_valid_i = 1'b1;
        s_data_i  = d;
        @(negedge clk_i);
        s_valid_i = 1'b0;
        chk("push_we", 32'(rawp_we_o), 32'd1);
        chk("push_adr", 32'(rawp_adr_o), adr);
        chk("push_dat", rawp_dat_o, d);
    endtask

    task automatic restart(input logic [LW-1:0] base, input logic [LW-1:0] len, input logic [LW-1:0] wmark);
        cfg_en_i    = 1'b0;
        s_valid_i   = 1'b0;
        rd_ptr_we_i = 1'b0;
        repeat (3) @(negedge clk_i);
        cfg_base_i  = base;
        cfg_len_i   = len;
        cfg_wmark_i = wmark;
        cfg_en_i    = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic load_rd(input logic [LW-1:0] p);
        rd_ptr_i    = p;
        rd_ptr_we_i = 1'b1;
        @(negedge clk_i);
        rd_ptr_we_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, bad, errc;
        rst_i = 1'b1; s_valid_i = 1'b0; s_data_i = '0; cfg_en_i = 1'b0;
        cfg_base_i = '0; cfg_len_i = '0; cfg_wmark_i = '0; rd_ptr_i = '0; rd_ptr_we_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_rdy", 32'(s_ready_o), 32'd0);
        chk("rst_adr", 32'(rawp_adr_o), 32'd0);
        chk("rst_dat", rawp_dat_o, 32'd0);
        chk("rst_we", 32'(rawp_we_o), 32'd0);
        chk("rst_wr", 32'(wr_ptr_o), 32'd0);
        chk("rst_lvl", 32'(level_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        rst_i = 1'b0;

        // four back-to-back words at base 16
        cfg_base_i = 10'd16; cfg_len_i = 10'd8; cfg_en_i = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) push(32'hA0 + i, 32'h40 + 4 * i);
        chk("b2b_wr", 32'(wr_ptr_o), 32'd4);
        chk("b2b_lvl", 32'(level_o), 32'd4);
        @(negedge clk_i);
        chk("b2b_pulse", 32'(rawp_we_o), 32'd0);

        // fill to len-1, then free three slots
        restart(10'h20, 10'd8, 10'd0);
        acc = 0;
        s_valid_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (s_ready_o) acc++;
            s_data_i = k;
            @(negedge clk_i);
        end
        chk("full_acc", 32'(acc), 32'd7);
        chk("full_rdy", 32'(s_ready_o), 32'd0);
        chk("full_lvl", 32'(level_o), 32'd7);
        load_rd(10'd3);
        chk("free_rdy", 32'(s_ready_o), 32'd1);
        chk("free_lvl", 32'(level_o), 32'd4);
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            if (s_ready_o) acc++;
            @(negedge clk_i);
        end
        s_valid_i = 1'b0;
        chk("free_acc", 32'(acc), 32'd3);
        chk("free_lvl2", 32'(level_o), 32'd7);
        chk("free_wr", 32'(wr_ptr_o), 32'd2);

        // wrap in a 4-word ring at base 0x30
        restart(10'h30, 10'd4, 10'd0);
        push(32'hB0, 32'hC0);
        push(32'hB1, 32'hC4);
        push(32'hB2, 32'hC8);
        chk("wrap_full", 32'(s_ready_o), 32'd0);
        load_rd(10'd3);
        chk("wrap_lvl0", 32'(level_o), 32'd0);
        push(32'hB3, 32'hCC);
        push(32'hB4, 32'hC0);
        push(32'hB5, 32'hC4);
        chk("wrap_wr", 32'(wr_ptr_o), 32'd2);
        chk("wrap_lvl", 32'(level_o), 32'd3);

        // accept attempt and rd_ptr load in the same cycle while full
        restart(10'd0, 10'd8, 10'd0);
        s_valid_i = 1'b1;
        repeat (7) @(negedge clk_i);
        chk("same_lvl", 32'(level_o), 32'd7);
        chk("same_rdy", 32'(s_ready_o), 32'd0);
        load_rd(10'd2);
        chk("same_nowr", 32'(rawp_we_o), 32'd0);
        chk("same_rdy2", 32'(s_ready_o), 32'd1);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        chk("same_we", 32'(rawp_we_o), 32'd1);
        chk("same_adr", 32'(rawp_adr_o), 32'h1C);
        chk("same_lvl2", 32'(level_o), 32'd6);
        load_rd(10'd8);
        chk("rd_oob", 32'(level_o), 32'd6);

        // watermark interrupt at 3 words
        restart(10'd0, 10'd8, 10'd3);
        push(32'h10, 32'h0);
        push(32'h11, 32'h4);
        chk("irq_lo", 32'(irq_o), 32'd0);
        push(32'h12, 32'h8);
        chk("irq_lvl", 32'(level_o), 32'd3);
        chk("irq_lag", 32'(irq_o), 32'd0);
        @(negedge clk_i);
        chk("irq_hi", 32'(irq_o), IRQ_ON);
        load_rd(10'd3);
        chk("irq_lvl0", 32'(level_o), 32'd0);
        chk("irq_hold", 32'(irq_o), IRQ_ON);
        @(negedge clk_i);
        chk("irq_fall", 32'(irq_o), 32'd0);

        // ring runs past RAM depth: word 28 lands at 0x200
        restart(10'd100, 10'd100, 10'd0);
        acc = 0; bad = -1; errc = -1;
        s_valid_i = 1'b1;
        for (int t = 0; t < 80; t++) begin
            if (err_o) begin
                errc = t;
                break;
            end
            if (s_ready_o) begin
                if (100 + acc >= RAM_WORDS && bad < 0) bad = t;
                acc++;
            end
            @(negedge clk_i);
        end
        s_valid_i = 1'b0;
        chk("err_seen", 32'(errc >= 0), 32'd1);
        chk("err_lat", 32'(errc - 1 - bad), 32'd2);
        chk("err_acc", 32'(acc), 32'd31);
        chk("err_rdy", 32'(s_ready_o), 32'd0);
        @(negedge clk_i);
        chk("err_hold", 32'(err_o), 32'd1);
        chk("err_irq", 32'(irq_o), IRQ_ON);
        cfg_en_i = 1'b0;
        @(negedge clk_i);
        chk("err_clr", 32'(err_o), 32'd0);
        chk("err_idle_rdy", 32'(s_ready_o), 32'd0);
        chk("err_idle_wr", 32'(wr_ptr_o), 32'd0);
        chk("err_idle_lvl", 32'(level_o), 32'd0);

        // reset on the edge that would have accepted a word
        restart(10'd0, 10'd8, 10'd0);
        s_valid_i = 1'b1;
        s_data_i  = 32'h55;
        rst_i     = 1'b1;
        @(negedge clk_i);
        s_valid_i = 1'b0;
        chk("rst_drop_we", 32'(rawp_we_o), 32'd0);
        chk("rst_drop_rdy", 32'(s_ready_o), 32'd0);
        chk("rst_drop_wr", 32'(wr_ptr_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
